// File: rtl/ram16x4_pkg.sv
// Shared constants for the ram16x4 arbiter: geometry, FSM state codes and requester indices.
package ram16x4_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;
endpackage

// File: rtl/ram16x4.sv
// 16x4 single-port RAM: synchronous write, combinational read.
module ram16x4 (
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [3:0] data_in,
    output logic [3:0] data_out
);
    logic [3:0] mem [16];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data_in;
        end
    end

    assign data_out = mem[addr];
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on contention the requester not granted most recently wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    // last_q = 1 means requester 1 was granted most recently, so requester 0 is favoured
    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        last_d = last_q;
        if (advance && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/ram16x4_arbiter.sv
// Clears the RAM after reset, then grants it to one of two requesters per cycle
// and returns read data on a per-requester response channel one cycle later.
module ram16x4_arbiter #(
    parameter int                ADDR_W       = 4,
    parameter int                DATA_W       = 4,
    parameter bit                ENABLE_CLEAR = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              init_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
    logic              run;
    logic [1:0]        arb_req;
    logic [1:0]        gnt;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (|gnt),
        .gnt     (gnt)
    );

    // Requests are masked out of the arbiter outside RUN so the pointer only moves on real transfers
    always_comb begin
        run     = !rst && (state_q == ram16x4_pkg::ST_RUN);
        arb_req = run ? {req1_valid, req0_valid} : 2'b00;

        req0_ready = gnt[ram16x4_pkg::REQ0];
        req1_ready = gnt[ram16x4_pkg::REQ1];

        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst && (state_q == ram16x4_pkg::ST_CLEAR)) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt_q;
            ram_wdata = CLEAR_VAL;
        end else if (gnt[ram16x4_pkg::REQ0]) begin
            ram_we    = req0_we;
            ram_addr  = req0_addr;
            ram_wdata = req0_wdata;
        end else if (gnt[ram16x4_pkg::REQ1]) begin
            ram_we    = req1_we;
            ram_addr  = req1_addr;
            ram_wdata = req1_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        if (state_q == ram16x4_pkg::ST_CLEAR) begin
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                state_d     = ram16x4_pkg::ST_RUN;
                init_done_d = 1'b1;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end else begin
            init_done_d = 1'b1;
        end

        rsp0_valid_d = gnt[ram16x4_pkg::REQ0] && !req0_we;
        rsp1_valid_d = gnt[ram16x4_pkg::REQ1] && !req1_we;
        rsp0_rdata_d = rsp0_valid_d ? ram_rdata : rsp0_rdata_q;
        rsp1_rdata_d = rsp1_valid_d ? ram_rdata : rsp1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ENABLE_CLEAR ? ram16x4_pkg::ST_CLEAR : ram16x4_pkg::ST_RUN;
            clr_cnt_q    <= '0;
            init_done_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            init_done_q  <= init_done_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign init_done  = init_done_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;
endmodule

// File: tb/tb_ram16x4_arbiter.sv
// Bench for ram16x4_arbiter driving a real ram16x4; a memory-array model checks every cycle.
module tb_ram16x4_arbiter;
    localparam logic [3:0] TB_CLEAR = 4'h0;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_we;
    logic [3:0] req0_addr, req0_wdata;
    logic       rsp0_valid;
    logic [3:0] rsp0_rdata;
    logic       req1_valid, req1_ready, req1_we;
    logic [3:0] req1_addr, req1_wdata;
    logic       rsp1_valid;
    logic [3:0] rsp1_rdata;
    logic       init_done;
    logic       ram_we;
    logic [3:0] ram_addr, ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram16x4_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .init_done  (init_done),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    ram16x4 u_ram (
        .clk      (clk),
        .we       (ram_we),
        .addr     (ram_addr),
        .data_in  (ram_wdata),
        .data_out (ram_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: memory contents, cycles since reset release, last granted requester,
    // pending responses and the response data each requester must currently show.
    logic [3:0] m_mem [16];
    int         m_cyc  = 0;
    bit         m_last = 1'b1;
    bit         m_pend0, m_pend1;
    logic [3:0] m_rd0, m_rd1;
    bit         armed  = 1'b0;
    bit         g0, g1;
    logic [3:0] q0 [$];
    logic [3:0] q1 [$];
    int         gq [$];

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ram_we", ram_we, 1'b0);
            chk("rst_ready0", req0_ready, 1'b0);
            chk("rst_ready1", req1_ready, 1'b0);
            if (armed) begin
                chk("rsp0_valid", rsp0_valid, m_pend0);
                chk("rsp1_valid", rsp1_valid, m_pend1);
            end
            m_cyc   = 0;
            m_last  = 1'b1;
            m_pend0 = 1'b0;
            m_pend1 = 1'b0;
            m_rd0   = 4'h0;
            m_rd1   = 4'h0;
            armed   = 1'b1;
        end else if (armed) begin
            chk("rsp0_valid", rsp0_valid, m_pend0);
            chk("rsp1_valid", rsp1_valid, m_pend1);
            chk("rsp0_rdata", rsp0_rdata, m_rd0);
            chk("rsp1_rdata", rsp1_rdata, m_rd1);
            if (rsp0_valid) q0.push_back(rsp0_rdata);
            if (rsp1_valid) q1.push_back(rsp1_rdata);
            m_pend0 = 1'b0;
            m_pend1 = 1'b0;
            if (m_cyc < 16) begin
                chk("clr_we", ram_we, 1'b1);
                chk("clr_addr", ram_addr, m_cyc);
                chk("clr_data", ram_wdata, TB_CLEAR);
                chk("clr_ready0", req0_ready, 1'b0);
                chk("clr_ready1", req1_ready, 1'b0);
                chk("clr_init_done", init_done, 1'b0);
                m_mem[m_cyc] = TB_CLEAR;
                m_cyc++;
            end else begin
                chk("run_init_done", init_done, 1'b1);
                g0 = req0_valid && (!req1_valid || m_last);
                g1 = req1_valid && !g0;
                chk("ready0", req0_ready, g0);
                chk("ready1", req1_ready, g1);
                chk("ram_we", ram_we, g0 ? req0_we : (g1 ? req1_we : 1'b0));
                if (g0) begin
                    chk("ram_addr0", ram_addr, req0_addr);
                    gq.push_back(0);
                    m_last = 1'b0;
                    if (req0_we) begin
                        chk("ram_wdata0", ram_wdata, req0_wdata);
                        m_mem[req0_addr] = req0_wdata;
                    end else begin
                        m_pend0 = 1'b1;
                        m_rd0   = m_mem[req0_addr];
                    end
                end else if (g1) begin
                    chk("ram_addr1", ram_addr, req1_addr);
                    gq.push_back(1);
                    m_last = 1'b1;
                    if (req1_we) begin
                        chk("ram_wdata1", ram_wdata, req1_wdata);
                        m_mem[req1_addr] = req1_wdata;
                    end else begin
                        m_pend1 = 1'b1;
                        m_rd1   = m_mem[req1_addr];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int port, input bit we, input logic [3:0] a, input logic [3:0] d);
        logic rdy;
        rdy = 1'b0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            rdy = (port == 0) ? req0_ready : req1_ready;
            if (rdy) break;
        end
        chk("xfer_handshake", rdy, 1'b1);
        @(posedge clk);
        #1;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         wec, done_cyc, wait_n;
        bit         a0, a1;
        logic [3:0] tab [16];
        tab = '{4'h0, 4'h3, 4'h6, 4'h9, 4'hC, 4'hF, 4'h2, 4'h5,
                4'h8, 4'hB, 4'hE, 4'h1, 4'h4, 4'h7, 4'hA, 4'hD};
        rst = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 4'h0; req0_wdata = 4'h0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 4'h0; req1_wdata = 4'h0;

        // Reset state and clear sequence
        repeat (2) tick();
        chk("reset_init_done", init_done, 1'b0);
        chk("reset_rsp0_valid", rsp0_valid, 1'b0);
        chk("reset_rsp1_valid", rsp1_valid, 1'b0);
        chk("reset_rsp0_rdata", rsp0_rdata, 4'h0);
        chk("reset_rsp1_rdata", rsp1_rdata, 4'h0);
        rst = 1'b0;
        wec = 0;
        done_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ram_we) wec++;
            if (init_done && done_cyc == 0) done_cyc = c;
        end
        chk("clear_we_cycles", wec, 16);
        chk("init_done_cycle", done_cyc, 17);
        tick();
        q0.delete();
        for (int i = 0; i < 16; i++) xfer(0, 1'b0, 4'(i), 4'h0);
        repeat (2) tick();
        chk("clear_rb_count", q0.size(), 16);
        for (int i = 0; i < q0.size() && i < 16; i++) chk("clear_readback", q0[i], 4'h0);

        // Request held valid across the clear
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'h5;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        wait_n = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req0_ready) break;
            wait_n++;
        end
        chk("held_ready_wait", wait_n, 16);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("held_rsp_valid", rsp0_valid, 1'b1);
        chk("held_rsp_rdata", rsp0_rdata, 4'h0);
        tick();

        // Contention: both requesters read every cycle
        xfer(1, 1'b1, 4'h2, 4'h6);
        xfer(1, 1'b1, 4'h9, 4'h3);
        q0.delete(); q1.delete(); gq.delete();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'h2;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'h9;
        repeat (8) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) tick();
        chk("cont_grant_count", gq.size(), 8);
        for (int k = 0; k < gq.size() && k < 8; k++) chk("cont_grant_seq", gq[k], k % 2);
        chk("cont_rsp0_count", q0.size(), 4);
        chk("cont_rsp1_count", q1.size(), 4);
        for (int k = 0; k < q0.size(); k++) chk("cont_rsp0_data", q0[k], 4'h6);
        for (int k = 0; k < q1.size(); k++) chk("cont_rsp1_data", q1[k], 4'h3);

        // Write via requester 1, read back via requester 0
        for (int i = 0; i < 16; i++) xfer(1, 1'b1, 4'(i), 4'((i * 3) & 15));
        q0.delete();
        for (int i = 0; i < 16; i++) xfer(0, 1'b0, 4'(i), 4'h0);
        repeat (2) tick();
        chk("wr_rb_count", q0.size(), 16);
        for (int i = 0; i < q0.size() && i < 16; i++) chk("wr_rb_data", q0[i], tab[i]);

        // Cross-requester read-after-write
        xfer(1, 1'b0, 4'h0, 4'h0);
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'h7; req0_wdata = 4'hA;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'h7;
        @(negedge clk);
        chk("raw_grant0", req0_ready, 1'b1);
        chk("raw_nogrant1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("raw_grant1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("raw_rsp1_valid", rsp1_valid, 1'b1);
        chk("raw_rsp1_rdata", rsp1_rdata, 4'hA);
        tick();

        // Reset in the cycle after a read grant
        xfer(0, 1'b1, 4'h3, 4'hF);
        xfer(0, 1'b0, 4'h4, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("mid_rst_clear_addr", ram_addr, 4'h0);
        repeat (18) @(negedge clk);
        tick();
        xfer(0, 1'b0, 4'h3, 4'h0);
        @(negedge clk);
        chk("mid_rst_rb_valid", rsp0_valid, 1'b1);
        chk("mid_rst_rb_data", rsp0_rdata, 4'h0);
        tick();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            tick();
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_we    = 1'($urandom_range(0, 1));
                req0_addr  = 4'($urandom);
                req0_wdata = 4'($urandom);
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_we    = 1'($urandom_range(0, 1));
                req1_addr  = 4'($urandom);
                req1_wdata = 4'($urandom);
            end
            rst = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
